// File: rtl/wb_regfile.sv
// Write-back stage and 32-entry register file with write-first read bypass
// and a retired-write counter.
module wb_regfile #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_in,
  input  logic              Reg_Write_in,
  input  logic              MemtoReg_in,
  input  logic [DATA_W-1:0] data_memory_output_in,
  input  logic [DATA_W-1:0] ALU_Output_in,
  input  logic [4:0]        MEM_WB_Rd_in,
  input  logic [4:0]        Rs_addr_in,
  input  logic [4:0]        Rt_addr_in,
  output logic [DATA_W-1:0] Rs_data_out,
  output logic [DATA_W-1:0] Rt_data_out,
  output logic [DATA_W-1:0] WB_data_out,
  output logic [31:0]       wb_count_out
);

  localparam int NREGS = 32;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [31:0]       wb_count_q;
  logic [31:0]       wb_count_d;
  logic              commit;

  // Register 0 is never targeted by a commit, so its entry stays at its reset value.
  assign WB_data_out = MemtoReg_in ? data_memory_output_in : ALU_Output_in;
  assign commit      = Reg_Write_in && (MEM_WB_Rd_in != 5'd0);
  assign wb_count_d  = commit ? wb_count_q + 32'd1 : wb_count_q;

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (commit) begin
      regs_q[MEM_WB_Rd_in] <= WB_data_out;
    end
  end

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      wb_count_q <= '0;
    end else begin
      wb_count_q <= wb_count_d;
    end
  end

  // Write-first: a commit to the addressed register is visible in the same cycle.
  function automatic logic [DATA_W-1:0] read_port(
    input logic [4:0]        addr,
    input logic              wr_en,
    input logic [4:0]        wr_addr,
    input logic [DATA_W-1:0] wr_data,
    input logic [DATA_W-1:0] stored
  );
    if (addr == 5'd0) begin
      return '0;
    end else if (wr_en && (wr_addr == addr)) begin
      return wr_data;
    end else begin
      return stored;
    end
  endfunction

  assign Rs_data_out  = read_port(Rs_addr_in, commit, MEM_WB_Rd_in, WB_data_out, regs_q[Rs_addr_in]);
  assign Rt_data_out  = read_port(Rt_addr_in, commit, MEM_WB_Rd_in, WB_data_out, regs_q[Rt_addr_in]);
  assign wb_count_out = wb_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed and randomized bench for wb_regfile against an array/counter reference model.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        reset_in;
  logic        Reg_Write_in;
  logic        MemtoReg_in;
  logic [31:0] data_memory_output_in;
  logic [31:0] ALU_Output_in;
  logic [4:0]  MEM_WB_Rd_in;
  logic [4:0]  Rs_addr_in;
  logic [4:0]  Rt_addr_in;
  logic [31:0] Rs_data_out;
  logic [31:0] Rt_data_out;
  logic [31:0] WB_data_out;
  logic [31:0] wb_count_out;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [32];
  logic [31:0] mcount;

  wb_regfile #(.DATA_W(32)) dut (
    .clk                   (clk),
    .reset_in              (reset_in),
    .Reg_Write_in          (Reg_Write_in),
    .MemtoReg_in           (MemtoReg_in),
    .data_memory_output_in (data_memory_output_in),
    .ALU_Output_in         (ALU_Output_in),
    .MEM_WB_Rd_in          (MEM_WB_Rd_in),
    .Rs_addr_in            (Rs_addr_in),
    .Rt_addr_in            (Rt_addr_in),
    .Rs_data_out           (Rs_data_out),
    .Rt_data_out           (Rt_data_out),
    .WB_data_out           (WB_data_out),
    .wb_count_out          (wb_count_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wb_val();
    return MemtoReg_in ? data_memory_output_in : ALU_Output_in;
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (Reg_Write_in && MEM_WB_Rd_in != 5'd0 && MEM_WB_Rd_in == a) return wb_val();
    return model[a];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    mcount = 32'h0;
  endtask

  // Called one time unit after a rising edge; returns one time unit after the next.
  task automatic apply(input logic rw, input logic mt, input logic [31:0] mem,
                       input logic [31:0] alu, input logic [4:0] rd,
                       input logic [4:0] rs, input logic [4:0] rt);
    Reg_Write_in = rw; MemtoReg_in = mt;
    data_memory_output_in = mem; ALU_Output_in = alu;
    MEM_WB_Rd_in = rd; Rs_addr_in = rs; Rt_addr_in = rt;
    #2;
    chk("wb_data", WB_data_out, wb_val());
    chk("rs_pre", Rs_data_out, exp_read(rs));
    chk("rt_pre", Rt_data_out, exp_read(rt));
    @(posedge clk);
    if (reset_in && rw && rd != 5'd0) begin
      model[rd] = mt ? mem : alu;
      mcount = mcount + 32'd1;
    end
    #1;
    chk("count", wb_count_out, mcount);
  endtask

  // Asserts reset mid-cycle with whatever inputs are present, holds over one edge.
  task automatic do_reset(input logic [4:0] rs);
    Rs_addr_in = rs;
    #2;
    reset_in = 1'b0;
    clear_model();
    #1;
    chk("rst_count", wb_count_out, 32'h0);
    chk("rst_rs", Rs_data_out, exp_read(rs));
    @(posedge clk);
    #1;
    chk("rst_count_hold", wb_count_out, 32'h0);
    Reg_Write_in = 1'b0;
    #1;
    chk("rst_rs_hold", Rs_data_out, exp_read(rs));
    reset_in = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_in = 1'b0;
    Reg_Write_in = 1'b0; MemtoReg_in = 1'b0;
    data_memory_output_in = '0; ALU_Output_in = '0;
    MEM_WB_Rd_in = '0; Rs_addr_in = 5'd4; Rt_addr_in = 5'd31;
    clear_model();
    #1;
    chk("init_count", wb_count_out, 32'h0);
    chk("init_rs", Rs_data_out, 32'h0);
    chk("init_rt", Rt_data_out, 32'h0);
    @(posedge clk);
    #1;
    reset_in = 1'b1;

    // Load reg5, then asynchronous reset clears it immediately.
    apply(1'b1, 1'b0, 32'h0, 32'h0000_1234, 5'd5, 5'd5, 5'd0);
    Reg_Write_in = 1'b0;
    do_reset(5'd5);

    // Reset held with a pending commit: bypass shown, nothing stored.
    Reg_Write_in = 1'b1; MemtoReg_in = 1'b0; ALU_Output_in = 32'h77; MEM_WB_Rd_in = 5'd7;
    do_reset(5'd7);
    apply(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd7);

    // Plain write then read on both ports.
    apply(1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF, 5'd8, 5'd1, 5'd2);
    apply(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd8, 5'd8);
    chk("deadbeef_rs", Rs_data_out, 32'hDEAD_BEEF);
    chk("deadbeef_rt", Rt_data_out, 32'hDEAD_BEEF);

    // Bypass of memory data over an older value.
    apply(1'b1, 1'b0, 32'h0, 32'h11, 5'd9, 5'd0, 5'd0);
    apply(1'b1, 1'b1, 32'hCAFE_F00D, 32'h2222, 5'd9, 5'd9, 5'd10);
    apply(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd10);
    chk("bypass_stored", Rs_data_out, 32'hCAFE_F00D);

    // Register 0 write is dropped and not counted.
    apply(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
    chk("zero_rs", Rs_data_out, 32'h0);
    chk("zero_count", wb_count_out, 32'd3);

    // Write disabled: no store, no bypass, no count.
    apply(1'b0, 1'b0, 32'h0, 32'h55, 5'd3, 5'd3, 5'd3);
    apply(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd8);

    // Randomized traffic with occasional mid-cycle resets.
    for (int it = 0; it < 400; it++) begin
      logic [4:0] rd, rs, rt;
      rd = 5'($urandom_range(0, 7));
      rs = ($urandom_range(0, 1) == 1) ? rd : 5'($urandom_range(0, 7));
      rt = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 39) == 0) begin
        Reg_Write_in = 1'($urandom_range(0, 1));
        MEM_WB_Rd_in = rd;
        do_reset(rs);
      end else begin
        apply(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              $urandom, $urandom, rd, rs, rt);
      end
    end

    chk("final_count", wb_count_out, mcount);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
